// File: rtl/otter_input_conditioner.sv
// rtl/otter_input_conditioner.sv - per-channel synchroniser, debouncer and edge/toggle detector
module otter_input_conditioner #(
  parameter int                NUM_CH      = 5,
  parameter int                SYNC_STAGES = 2,
  parameter int                DB_CYCLES   = 500000,
  parameter logic [NUM_CH-1:0] TOGGLE_MASK = {NUM_CH{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] raw_in,
  output logic [NUM_CH-1:0] level_out,
  output logic [NUM_CH-1:0] rise_out,
  output logic [NUM_CH-1:0] fall_out,
  output logic [NUM_CH-1:0] toggle_out,
  output logic              any_rise
);

  localparam int             CW       = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q [NUM_CH];
  logic [SYNC_STAGES-1:0] sync_d [NUM_CH];
  logic [CW-1:0]          cnt_q  [NUM_CH];
  logic [CW-1:0]          cnt_d  [NUM_CH];
  logic [NUM_CH-1:0]      stable_q, stable_d;
  logic [NUM_CH-1:0]      level_q, level_d;
  logic [NUM_CH-1:0]      rise_q, rise_d;
  logic [NUM_CH-1:0]      fall_q, fall_d;
  logic [NUM_CH-1:0]      toggle_q, toggle_d;
  logic                   any_rise_q, any_rise_d;

  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < NUM_CH; i++) begin
      sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], raw_in[i]};
      cnt_d[i]  = cnt_q[i];
      if (sync_q[i][SYNC_STAGES-1] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        stable_d[i] = sync_q[i][SYNC_STAGES-1];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
    // Output stage registers the accepted level so level and its edge pulse appear together.
    level_d    = stable_q;
    rise_d     = stable_q & ~level_q;
    fall_d     = ~stable_q & level_q;
    toggle_d   = toggle_q ^ (rise_d & TOGGLE_MASK);
    any_rise_d = |rise_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        sync_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      stable_q   <= '0;
      level_q    <= '0;
      rise_q     <= '0;
      fall_q     <= '0;
      toggle_q   <= '0;
      any_rise_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        sync_q[i] <= sync_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
      stable_q   <= stable_d;
      level_q    <= level_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      toggle_q   <= toggle_d;
      any_rise_q <= any_rise_d;
    end
  end

  assign level_out  = level_q;
  assign rise_out   = rise_q;
  assign fall_out   = fall_q;
  assign toggle_out = toggle_q;
  assign any_rise   = any_rise_q;

endmodule

// File: tb/tb_otter_input_conditioner.sv
// tb/tb_otter_input_conditioner.sv - directed self-checking bench for otter_input_conditioner
module tb_otter_input_conditioner;

  logic       clk;
  logic       rst;
  logic [4:0] raw_in;
  logic [4:0] level_out;
  logic [4:0] rise_out;
  logic [4:0] fall_out;
  logic [4:0] toggle_out;
  logic       any_rise;

  int checks = 0;
  int passes = 0;

  otter_input_conditioner #(
    .NUM_CH     (5),
    .SYNC_STAGES(2),
    .DB_CYCLES  (4),
    .TOGGLE_MASK(5'b00100)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .raw_in    (raw_in),
    .level_out (level_out),
    .rise_out  (rise_out),
    .fall_out  (fall_out),
    .toggle_out(toggle_out),
    .any_rise  (any_rise)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    raw_in = 5'b00000;
    repeat (3) step();
    rst = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    raw_in = 5'b11111;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if ({level_out, rise_out, fall_out, toggle_out, any_rise} !== 21'd0)
        $display("FAIL reset_hold cyc=%0d got lvl=%b rise=%b fall=%b tog=%b any=%b want all 0",
                 k, level_out, rise_out, fall_out, toggle_out, any_rise);
      else passes++;
    end
    rst = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      checks++;
      if (level_out !== 5'b00000 || rise_out !== 5'b00000)
        $display("FAIL reset_latency step=%0d got lvl=%b rise=%b want 00000", k, level_out, rise_out);
      else passes++;
    end
    step();
    checks++;
    if (level_out !== 5'b11111 || rise_out !== 5'b11111 || any_rise !== 1'b1)
      $display("FAIL reset_rise got lvl=%b rise=%b any=%b want 11111 11111 1", level_out, rise_out, any_rise);
    else passes++;
    checks++;
    if (toggle_out !== 5'b00100) $display("FAIL reset_toggle got %b want 00100", toggle_out);
    else passes++;
    step();
    checks++;
    if (rise_out !== 5'b00000 || any_rise !== 1'b0 || level_out !== 5'b11111)
      $display("FAIL reset_pulse_end got rise=%b any=%b lvl=%b want 00000 0 11111", rise_out, any_rise, level_out);
    else passes++;
  endtask

  task automatic test_press_release();
    logic [4:0] want_tog;
    do_reset();
    for (int ph = 0; ph < 3; ph++) begin
      raw_in[2] = (ph != 1);
      for (int k = 1; k <= 6; k++) begin
        step();
        checks++;
        if (rise_out[2] !== 1'b0 || fall_out[2] !== 1'b0)
          $display("FAIL press_early ph=%0d step=%0d got rise=%b fall=%b want 0 0", ph, k, rise_out[2], fall_out[2]);
        else passes++;
      end
      step();
      want_tog = (ph == 2) ? 5'b00000 : 5'b00100;
      checks++;
      if (ph != 1 && (rise_out !== 5'b00100 || fall_out !== 5'b00000 || level_out !== 5'b00100))
        $display("FAIL press_rise ph=%0d got rise=%b fall=%b lvl=%b want 00100 00000 00100", ph, rise_out, fall_out, level_out);
      else if (ph == 1 && (fall_out !== 5'b00100 || rise_out !== 5'b00000 || level_out !== 5'b00000))
        $display("FAIL release_fall got rise=%b fall=%b lvl=%b want 00000 00100 00000", rise_out, fall_out, level_out);
      else passes++;
      checks++;
      if (toggle_out !== want_tog) $display("FAIL press_toggle ph=%0d got %b want %b", ph, toggle_out, want_tog);
      else passes++;
      step();
      checks++;
      if (rise_out !== 5'b00000 || fall_out !== 5'b00000)
        $display("FAIL press_pulse_end ph=%0d got rise=%b fall=%b want 0", ph, rise_out, fall_out);
      else passes++;
    end
  endtask

  task automatic test_bounce();
    int dur [20] = '{1, 2, 3, 1, 2, 3, 3, 1, 2, 2, 3, 1, 2, 3, 1, 2, 3, 2, 1, 3};
    int bad = 0;
    do_reset();
    for (int s = 0; s < 20; s++) begin
      raw_in[0] = (s % 2 == 0);
      for (int c = 0; c < dur[s]; c++) begin
        step();
        if (rise_out !== 5'b0 || fall_out !== 5'b0 || level_out !== 5'b0) bad++;
      end
    end
    checks++;
    if (bad != 0) $display("FAIL bounce_quiet got %0d noisy cycles want 0", bad);
    else passes++;
    raw_in[0] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      checks++;
      if (rise_out[0] !== 1'b0) $display("FAIL bounce_early step=%0d got rise=%b want 0", k, rise_out[0]);
      else passes++;
    end
    step();
    checks++;
    if (rise_out !== 5'b00001 || level_out !== 5'b00001)
      $display("FAIL bounce_rise got rise=%b lvl=%b want 00001 00001", rise_out, level_out);
    else passes++;
    checks++;
    if (toggle_out !== 5'b00000) $display("FAIL bounce_toggle got %b want 00000", toggle_out);
    else passes++;
    step();
    checks++;
    if (rise_out !== 5'b00000) $display("FAIL bounce_single got rise=%b want 00000", rise_out);
    else passes++;
  endtask

  task automatic test_glitch();
    do_reset();
    raw_in[1] = 1'b1;
    repeat (3) step();
    raw_in[1] = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      checks++;
      if (level_out[1] !== 1'b0 || rise_out[1] !== 1'b0 || fall_out[1] !== 1'b0)
        $display("FAIL glitch cyc=%0d got lvl=%b rise=%b fall=%b want 0", k, level_out[1], rise_out[1], fall_out[1]);
      else passes++;
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    raw_in = 5'b10011;
    for (int k = 1; k <= 6; k++) begin
      step();
      checks++;
      if (any_rise !== 1'b0 || rise_out !== 5'b00000)
        $display("FAIL simul_early step=%0d got rise=%b any=%b want 0", k, rise_out, any_rise);
      else passes++;
    end
    step();
    checks++;
    if (rise_out !== 5'b10011 || any_rise !== 1'b1)
      $display("FAIL simul_rise got rise=%b any=%b want 10011 1", rise_out, any_rise);
    else passes++;
    step();
    checks++;
    if (rise_out !== 5'b00000 || any_rise !== 1'b0 || level_out !== 5'b10011)
      $display("FAIL simul_end got rise=%b any=%b lvl=%b want 00000 0 10011", rise_out, any_rise, level_out);
    else passes++;
  endtask

  task automatic test_reset_midcount();
    do_reset();
    raw_in[3] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (rise_out[3] !== 1'b0) $display("FAIL mid_pre step=%0d got rise=%b want 0", k, rise_out[3]);
      else passes++;
    end
    rst = 1'b1;
    repeat (2) step();
    checks++;
    if (level_out !== 5'b0 || rise_out !== 5'b0) $display("FAIL mid_rst got lvl=%b rise=%b want 0", level_out, rise_out);
    else passes++;
    rst = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      checks++;
      if (rise_out[3] !== 1'b0 || level_out[3] !== 1'b0)
        $display("FAIL mid_restart step=%0d got rise=%b lvl=%b want 0", k, rise_out[3], level_out[3]);
      else passes++;
    end
    step();
    checks++;
    if (rise_out !== 5'b01000 || level_out !== 5'b01000)
      $display("FAIL mid_rise got rise=%b lvl=%b want 01000 01000", rise_out, level_out);
    else passes++;
  endtask

  initial begin
    rst    = 1'b1;
    raw_in = 5'b00000;
    test_reset();
    test_press_release();
    test_bounce();
    test_glitch();
    test_simultaneous();
    test_reset_midcount();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
